// File: rtl/trigger_event_gen.sv
// Trigger event generator: masked compare of each sample, level/edge condition encoding into
// a 2-bit event, carried through a 1-deep register slice. Optional holdoff: TRIGGER_EVENT_HOLDOFF_EN.
module trigger_event_gen #(
  parameter int SDW = 32,
  parameter int HCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SDW-1:0] cfg_msk,
  input  logic [SDW-1:0] cfg_val,
  input  logic [1:0]     cfg_clr,
  input  logic [1:0]     cfg_inc,
  input  logic [1:0]     cfg_dec,
  input  logic [HCW-1:0] cfg_hld,
  input  logic           sti_valid,
  output logic           sti_ready,
  input  logic [SDW-1:0] sti_data,
  output logic           sto_valid,
  input  logic           sto_ready,
  output logic [SDW-1:0] sto_data,
  output logic [1:0]     sto_tevent
);

  localparam logic [1:0] EV_IDLE = 2'b00;
  localparam logic [1:0] EV_CLR  = 2'b01;
  localparam logic [1:0] EV_INC  = 2'b10;
  localparam logic [1:0] EV_DEC  = 2'b11;

  function automatic logic cond_hit(input logic [1:0] sel, input logic m, input logic pm);
    case (sel)
      2'b01:   return m;
      2'b10:   return m & ~pm;
      2'b11:   return ~m & pm;
      default: return 1'b0;
    endcase
  endfunction

  // Clear dominates; simultaneous increment and decrement cancel to idle.
  function automatic logic [1:0] encode_event(input logic clr, input logic inc, input logic dec);
    if (clr)             return EV_CLR;
    else if (inc && !dec) return EV_INC;
    else if (dec && !inc) return EV_DEC;
    else                 return EV_IDLE;
  endfunction

  logic           sto_valid_q, sto_valid_d;
  logic [SDW-1:0] sto_data_q,  sto_data_d;
  logic [1:0]     sto_tevent_q, sto_tevent_d;
  logic           prv_match_q, prv_match_d;

  logic           sti_transfer;
  logic           match;
  logic [1:0]     raw_ev;
  logic [1:0]     ev;

  // Input stage: compare and condition evaluation
  always_comb begin
    sti_ready    = ~sto_valid_q | sto_ready;
    sti_transfer = sti_valid & sti_ready;
    match        = ((sti_data ^ cfg_val) & cfg_msk) == '0;
    raw_ev       = encode_event(cond_hit(cfg_clr, match, prv_match_q),
                                cond_hit(cfg_inc, match, prv_match_q),
                                cond_hit(cfg_dec, match, prv_match_q));
  end

`ifdef TRIGGER_EVENT_HOLDOFF_EN
  logic [HCW-1:0] hld_cnt_q, hld_cnt_d;

  // Holdoff counts input transfers, not cycles, so stalls do not shorten it.
  always_comb begin
    ev        = raw_ev;
    hld_cnt_d = hld_cnt_q;
    if (sti_transfer) begin
      if (raw_ev == EV_CLR) begin
        hld_cnt_d = '0;
      end else if (hld_cnt_q != '0) begin
        hld_cnt_d = hld_cnt_q - HCW'(1);
        if (raw_ev[1]) ev = EV_IDLE;
      end else if (raw_ev[1]) begin
        hld_cnt_d = cfg_hld;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hld_cnt_q <= '0;
    else     hld_cnt_q <= hld_cnt_d;
  end
`else
  logic unused_hld;
  assign unused_hld = ^cfg_hld;

  always_comb begin
    ev = raw_ev;
  end
`endif

  always_comb begin
    sto_valid_d  = sto_valid_q;
    sto_data_d   = sto_data_q;
    sto_tevent_d = sto_tevent_q;
    prv_match_d  = prv_match_q;
    if (sti_transfer) begin
      sto_valid_d  = 1'b1;
      sto_data_d   = sti_data;
      sto_tevent_d = ev;
      prv_match_d  = match;
    end else if (sto_valid_q && sto_ready) begin
      sto_valid_d  = 1'b0;
    end
  end

  // Output stage: register slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_valid_q  <= 1'b0;
      sto_data_q   <= '0;
      sto_tevent_q <= EV_IDLE;
      prv_match_q  <= 1'b0;
    end else begin
      sto_valid_q  <= sto_valid_d;
      sto_data_q   <= sto_data_d;
      sto_tevent_q <= sto_tevent_d;
      prv_match_q  <= prv_match_d;
    end
  end

  assign sto_valid  = sto_valid_q;
  assign sto_data   = sto_data_q;
  assign sto_tevent = sto_tevent_q;

endmodule

// File: tb/tb_trigger_event_gen.sv
// Directed, table-driven bench for trigger_event_gen with hand-written backpressure,
// mid-stream reset and (when TRIGGER_EVENT_HOLDOFF_EN is defined) holdoff sequences.
module tb_trigger_event_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_msk, cfg_val;
  logic [1:0]  cfg_clr, cfg_inc, cfg_dec;
  logic [7:0]  cfg_hld;
  logic        sti_valid, sti_ready, sto_valid, sto_ready;
  logic [31:0] sti_data, sto_data;
  logic [1:0]  sto_tevent;

  int errors = 0;
  int checks = 0;

  trigger_event_gen #(.SDW(32), .HCW(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_msk(cfg_msk), .cfg_val(cfg_val),
    .cfg_clr(cfg_clr), .cfg_inc(cfg_inc), .cfg_dec(cfg_dec), .cfg_hld(cfg_hld),
    .sti_valid(sti_valid), .sti_ready(sti_ready), .sti_data(sti_data),
    .sto_valid(sto_valid), .sto_ready(sto_ready),
    .sto_data(sto_data), .sto_tevent(sto_tevent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [31:0] msk;
    logic [31:0] val;
    logic [1:0]  clr;
    logic [1:0]  inc;
    logic [1:0]  dec;
    logic [31:0] data;
    logic [1:0]  ev;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] d, input logic [1:0] e);
    chk({name, " valid"}, {31'd0, sto_valid}, 32'd1);
    chk({name, " tevent"}, {30'd0, sto_tevent}, {30'd0, e});
    chk({name, " data"}, sto_data, d);
  endtask

  // One isolated transfer with sto_ready high; output checked one cycle later.
  task automatic xfer(input string name, input logic [31:0] d, input logic [1:0] e);
    @(negedge clk);
    sti_data  = d;
    sti_valid = 1'b1;
    @(negedge clk);
    sti_valid = 1'b0;
    check_out(name, d, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit pending;
    rst = 1'b1; cfg_msk = 32'hFF; cfg_val = 32'h55;
    cfg_clr = 2'b00; cfg_inc = 2'b00; cfg_dec = 2'b00; cfg_hld = 8'd0;
    sti_valid = 1'b0; sti_data = '0; sto_ready = 1'b1;

    //            rst   msk           val           clr    inc    dec    data          ev
    tab.push_back('{1'b1, 32'hFF,       32'h55,       2'd0, 2'd1, 2'd0, 32'h55,       2'b10});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd1, 2'd0, 32'h54,       2'b00});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd1, 2'd0, 32'h55,       2'b10});
    tab.push_back('{1'b1, 32'hFF,       32'h55,       2'd0, 2'd2, 2'd3, 32'h55,       2'b10});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd2, 2'd3, 32'h55,       2'b00});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd2, 2'd3, 32'h00,       2'b11});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd2, 2'd3, 32'h55,       2'b10});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd1, 2'd1, 2'd0, 32'h55,       2'b01});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd1, 2'd1, 32'h55,       2'b00});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd1, 2'd1, 2'd1, 32'h55,       2'b01});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd0, 2'd1, 32'h55,       2'b11});
    tab.push_back('{1'b0, 32'h0,        32'hAA,       2'd0, 2'd1, 2'd0, 32'h12,       2'b10});
    tab.push_back('{1'b0, 32'hFFFF0000, 32'hA5A50000, 2'd0, 2'd1, 2'd0, 32'hA5A51234, 2'b10});
    tab.push_back('{1'b0, 32'hFFFF0000, 32'hA5A50000, 2'd0, 2'd1, 2'd0, 32'hA5A41234, 2'b00});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd0, 2'd0, 2'd0, 32'h55,       2'b00});
    tab.push_back('{1'b0, 32'hFF,       32'h55,       2'd3, 2'd1, 2'd0, 32'h00,       2'b01});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset sto_valid", {31'd0, sto_valid}, 32'd0);
    chk("reset sto_tevent", {30'd0, sto_tevent}, 32'd0);
    chk("reset sto_data", sto_data, 32'd0);
    chk("reset sti_ready", {31'd0, sti_ready}, 32'd1);

    // Back-to-back table stream at full throughput
    pending = 1'b0;
    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk);
      if (pending) begin
        check_out($sformatf("vec%0d", i - 1), tab[i-1].data, tab[i-1].ev);
        pending = 1'b0;
      end
      if (tab[i].rst_first) begin
        sti_valid = 1'b0;
        do_reset();
      end
      cfg_msk = tab[i].msk; cfg_val = tab[i].val;
      cfg_clr = tab[i].clr; cfg_inc = tab[i].inc; cfg_dec = tab[i].dec;
      sti_data = tab[i].data; sti_valid = 1'b1;
      pending = 1'b1;
    end
    @(negedge clk);
    check_out($sformatf("vec%0d", tab.size() - 1), tab[tab.size()-1].data, tab[tab.size()-1].ev);
    sti_valid = 1'b0;
    @(negedge clk);
    chk("drain sto_valid", {31'd0, sto_valid}, 32'd0);

    // Backpressure: stalled sample must not disturb edge history or output
    do_reset();
    cfg_msk = 32'hFF; cfg_val = 32'h55; cfg_clr = 2'd0; cfg_inc = 2'd2; cfg_dec = 2'd3;
    sto_ready = 1'b1; sti_data = 32'h55; sti_valid = 1'b1;
    @(negedge clk);
    check_out("bp A", 32'h55, 2'b10);
    sto_ready = 1'b0; sti_data = 32'h00;
    #1;
    chk("bp sti_ready low", {31'd0, sti_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d sti_ready", k), {31'd0, sti_ready}, 32'd0);
      check_out($sformatf("bp stall%0d hold", k), 32'h55, 2'b10);
    end
    sto_ready = 1'b1;
    @(negedge clk);
    check_out("bp B", 32'h00, 2'b11);
    sti_data = 32'h55;
    @(negedge clk);
    check_out("bp C", 32'h55, 2'b10);
    sti_valid = 1'b0;
    @(negedge clk);
    chk("bp drained", {31'd0, sto_valid}, 32'd0);

    // Output holds while stalled with no new input
    sto_ready = 1'b0;
    xfer("hold D", 32'h54, 2'b11);
    @(negedge clk);
    check_out("hold D still", 32'h54, 2'b11);
    sto_ready = 1'b1;
    @(negedge clk);
    chk("hold D released", {31'd0, sto_valid}, 32'd0);

    // Mid-stream asynchronous reset drops output and clears edge history
    cfg_inc = 2'd1; cfg_dec = 2'd0;
    sto_ready = 1'b0;
    xfer("mid pre", 32'h55, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("mid rst sto_valid", {31'd0, sto_valid}, 32'd0);
    chk("mid rst sto_tevent", {30'd0, sto_tevent}, 32'd0);
    chk("mid rst sto_data", sto_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sto_ready = 1'b1;
    cfg_inc = 2'd2;
    xfer("mid post rising", 32'h55, 2'b10);

`ifdef TRIGGER_EVENT_HOLDOFF_EN
    // Holdoff of two transfers after each inc/dec
    do_reset();
    cfg_msk = 32'hFF; cfg_val = 32'h55; cfg_clr = 2'd0; cfg_inc = 2'd1; cfg_dec = 2'd0;
    cfg_hld = 8'd2;
    xfer("hld s0", 32'h55, 2'b10);
    xfer("hld s1", 32'h55, 2'b00);
    xfer("hld s2", 32'h55, 2'b00);
    xfer("hld s3", 32'h55, 2'b10);
    xfer("hld s4", 32'h55, 2'b00);
    cfg_clr = 2'd1;
    xfer("hld clear", 32'h55, 2'b01);
    cfg_clr = 2'd0;
    xfer("hld after clear", 32'h55, 2'b10);
    cfg_hld = 8'd0;
    xfer("hld zero a", 32'h55, 2'b00);
    xfer("hld zero b", 32'h55, 2'b00);
    xfer("hld zero c", 32'h55, 2'b10);
    xfer("hld zero d", 32'h55, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
